dram_ctrl: RTL and testbench
============================

DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter T_RP, default 5, meaning precharge cycles with RASn high before an activate.
REQ-002 SHALL have parameter T_RCD, default 5, meaning cycles from RASn low to first CASn low.
REQ-003 SHALL have parameter T_TMO, default 255, meaning the maximum cycles to wait for DRAM_valid on a read.
REQ-004 SHALL have port cpu_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port cpu_rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1, req_write in 1, req_addr in 21 (word address), req_wstrb in 4, req_wdata in 32.
REQ-007 SHALL have ports resp_valid out 1, resp_err out 1, resp_rdata out 32.
REQ-008 SHALL have DRAM-side ports DRAM_CSn out 1, DRAM_RASn out 1, DRAM_CASn out 1, DRAM_WEn out 4 (active-low byte enables), DRAM_A out 11, DRAM_D out 32, DRAM_Q in 32, DRAM_valid in 1.

Function
REQ-009 SHALL map req_addr[20:10] to row and {1'b0, req_addr[9:0]} to column on DRAM_A.
REQ-010 SHALL implement states IDLE, PRE, ACT, RD_CAS, RD_WAIT, WR_CAS, WR_REC.
REQ-011 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&&req_ready, and all req_* fields are captured into registers in that cycle.
REQ-012 SHALL keep the last activated row open (RASn held low) after each access (open-page policy) and track it with a row_open flag and an 11-bit open_row register.
REQ-013 SHALL on accept: row hit (row_open and row equal) -> RD_CAS or WR_CAS; row_open and miss -> PRE; no open row -> ACT.
REQ-014 SHALL in PRE drive RASn=1 and CASn=1 for exactly T_RP cycles, clear row_open, then go to ACT.
REQ-015 SHALL in ACT drive DRAM_A=row and RASn=0 for exactly T_RCD cycles, set row_open and open_row, then go to the CAS state.
REQ-016 SHALL in RD_CAS drive DRAM_A=column, CASn=0 and WEn=4'hF for one cycle, then enter RD_WAIT.
REQ-017 SHALL in RD_WAIT hold CASn=0 and the column until DRAM_valid=1; in that cycle it registers DRAM_Q into resp_rdata, pulses resp_valid for one cycle on the next edge, and returns to IDLE.
REQ-018 SHALL if DRAM_valid is not seen within T_TMO cycles of RD_WAIT, pulse resp_valid with resp_err=1 and resp_rdata=0, clear row_open, and return to IDLE via PRE.
REQ-019 SHALL in WR_CAS drive DRAM_A=column, DRAM_D=wdata, CASn=0 and WEn=~wstrb for one cycle; then WR_REC drives CASn=1 and WEn=4'hF for one cycle, pulses resp_valid (rdata 0, err 0), and returns to IDLE.
REQ-020 SHALL treat wstrb=4'h0 as a legal no-op write that still follows the full WR_CAS/WR_REC sequence and acknowledges.
REQ-021 SHALL drive DRAM_CSn=0 whenever row_open or state!=IDLE, else 1; WEn=4'hF and CASn=1 outside the CAS states.
REQ-022 SHALL ignore DRAM_valid outside RD_WAIT.
REQ-023 SHALL keep resp_valid a single-cycle pulse, with exactly one response per accepted request and in order.
REQ-024 SHALL count a timing counter as 8 bits; parameters larger than 255 are illegal.

Reset
REQ-025 SHALL on cpu_rst_n=0 asynchronously set state=IDLE, row_open=0, open_row=0, CSn=1, RASn=1, CASn=1, WEn=4'hF, A=0, D=0, req_ready=0 during reset, and resp_valid=0, resp_err=0, resp_rdata=0.
REQ-026 SHALL abort an in-flight access on reset mid-operation without emitting a response; the first cycle after release is IDLE with req_ready=1.

Structure
REQ-027 SHALL place the state enum, the default T_RP/T_RCD/T_TMO values, and the row/column width constants in package dram_ctrl_pkg.
REQ-028 SHALL use one sub-module, dram_timer: a loadable 8-bit down-counter with a done flag, shared by PRE, ACT and the read timeout.

Verification
REQ-029 SHALL cover a cold read: addr 0x00403, model Q=0xDEADBEEF -> ACT row 1 (5 cycles), CAS column 3, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-030 SHALL cover a row-hit write then read: write 0x00404 with wstrb 4'b0011 and data 0x12345678, then read it -> no PRE/ACT between, WEn=4'b1100, low half returns 0x5678.
REQ-031 SHALL cover a row miss: read 0x00403 then 0x00803 -> RASn high for exactly 5 cycles, then ACT with A=2.
REQ-032 SHALL cover a timeout: DRAM_valid held 0 -> resp_err=1 after 255 RD_WAIT cycles, next access performs ACT.
REQ-033 SHALL cover reset mid-RD_WAIT: cpu_rst_n low -> all DRAM strobes high immediately, no resp_valid, and a clean read after release.
REQ-034 SHALL cover back-to-back requests with req_valid held high -> req_ready low except in IDLE, responses in order, none dropped.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the open-page DRAM controller.
// Address split, timing defaults and the controller state encoding.
package dram_ctrl_pkg;

    localparam int ADDR_W = 21;
    localparam int ROW_W  = 11;
    localparam int COL_W  = 10;
    localparam int A_W    = 11;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 8;

    localparam int DEF_T_RP  = 5;
    localparam int DEF_T_RCD = 5;
    localparam int DEF_T_TMO = 255;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACT,
        RD_CAS,
        RD_WAIT,
        WR_CAS,
        WR_REC
    } state_t;

    function automatic logic [ROW_W-1:0] row_of(
        input logic [ADDR_W-1:0] a
    );
        return a[ADDR_W-1:COL_W];
    endfunction

    function automatic logic [A_W-1:0] col_of(
        input logic [ADDR_W-1:0] a
    );
        return {{(A_W-COL_W){1'b0}}, a[COL_W-1:0]};
    endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter shared by precharge, activate and read timeout.
// done marks the last cycle of a loaded interval.
module dram_timer
    import dram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/dram_ctrl.sv
// Single-port DRAM controller with an open-page policy.
// One request in flight; one response per accepted request.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int T_RP  = DEF_T_RP,
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_TMO = DEF_T_TMO
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [STRB_W-1:0] req_wstrb,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              DRAM_CSn,
    output logic              DRAM_RASn,
    output logic              DRAM_CASn,
    output logic [STRB_W-1:0] DRAM_WEn,
    output logic [A_W-1:0]    DRAM_A,
    output logic [DATA_W-1:0] DRAM_D,
    input  logic [DATA_W-1:0] DRAM_Q,
    input  logic              DRAM_valid
);

    localparam logic [CNT_W-1:0] RP_V  = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] RCD_V = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] TMO_V = CNT_W'(T_TMO);

    state_t state;
    state_t state_nxt;

    logic              row_open;
    logic [ROW_W-1:0]  open_row;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic              abort_q;

    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_done;
    logic [CNT_W-1:0]  tmr_val;

    logic              accept;
    logic              row_hit;
    logic              row_miss;
    logic [ROW_W-1:0]  req_row;

    assign req_row   = row_of(req_addr);
    assign req_ready = (state == IDLE) && cpu_rst_n;
    assign accept    = req_valid && req_ready;
    assign row_hit   = row_open && (req_row == open_row);
    assign row_miss  = row_open && (req_row != open_row);

    dram_timer u_timer (
        .clk      (cpu_clk),
        .rst_n    (cpu_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        row_hit: begin
                            state_nxt = req_write ? WR_CAS : RD_CAS;
                        end
                        row_miss: begin
                            state_nxt = PRE;
                            tmr_load  = 1'b1;
                            tmr_val   = RP_V;
                        end
                        !row_open: begin
                            state_nxt = ACT;
                            tmr_load  = 1'b1;
                            tmr_val   = RCD_V;
                        end
                        default: ;
                    endcase
                end
            end
            PRE: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    // A timed-out read has already answered; just close out.
                    if (abort_q) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = ACT;
                        tmr_load  = 1'b1;
                        tmr_val   = RCD_V;
                    end
                end
            end
            ACT: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_nxt = write_q ? WR_CAS : RD_CAS;
                end
            end
            RD_CAS: begin
                state_nxt = RD_WAIT;
                tmr_load  = 1'b1;
                tmr_val   = TMO_V;
            end
            RD_WAIT: begin
                tmr_en = 1'b1;
                if (DRAM_valid) begin
                    state_nxt = IDLE;
                end else if (tmr_done) begin
                    state_nxt = PRE;
                    tmr_load  = 1'b1;
                    tmr_val   = RP_V;
                end
            end
            WR_CAS:  state_nxt = WR_REC;
            WR_REC:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        DRAM_CSn  = !(row_open || state != IDLE);
        DRAM_RASn = !(row_open || state == ACT);
        DRAM_CASn = 1'b1;
        DRAM_WEn  = '1;
        DRAM_A    = '0;
        DRAM_D    = '0;
        unique case (state)
            ACT: begin
                DRAM_A = row_of(addr_q);
            end
            RD_CAS, RD_WAIT: begin
                DRAM_CASn = 1'b0;
                DRAM_A    = col_of(addr_q);
            end
            WR_CAS: begin
                DRAM_CASn = 1'b0;
                DRAM_WEn  = ~wstrb_q;
                DRAM_A    = col_of(addr_q);
                DRAM_D    = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state      <= IDLE;
            row_open   <= 1'b0;
            open_row   <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            abort_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_nxt;
            resp_valid <= 1'b0;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wstrb_q <= req_wstrb;
                wdata_q <= req_wdata;
                abort_q <= 1'b0;
                if (row_miss) begin
                    row_open <= 1'b0;
                end
            end
            unique case (state)
                ACT: begin
                    if (tmr_done) begin
                        row_open <= 1'b1;
                        open_row <= row_of(addr_q);
                    end
                end
                RD_WAIT: begin
                    if (DRAM_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= DRAM_Q;
                    end else if (tmr_done) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        row_open   <= 1'b0;
                        abort_q    <= 1'b1;
                    end
                end
                WR_REC: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with a small behavioural DRAM model.
// Expected values are hand-derived from the address map and timings.
module tb_dram_ctrl;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [20:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        DRAM_CSn;
    logic        DRAM_RASn;
    logic        DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic [31:0] DRAM_Q;
    logic        DRAM_valid;

    dram_ctrl dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst_n  (cpu_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .DRAM_CSn   (DRAM_CSn),
        .DRAM_RASn  (DRAM_RASn),
        .DRAM_CASn  (DRAM_CASn),
        .DRAM_WEn   (DRAM_WEn),
        .DRAM_A     (DRAM_A),
        .DRAM_D     (DRAM_D),
        .DRAM_Q     (DRAM_Q),
        .DRAM_valid (DRAM_valid)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    bit [31:0]   mem [int];
    logic        no_valid = 1'b0;
    logic [10:0] cur_row = '0;
    int          rd_cnt = 0;

    logic        prev_ras = 1'b1;
    logic        prev_cas = 1'b1;
    int          pre_run = 0;
    int          pre_events = 0;
    int          last_pre_len = 0;
    int          act_events = 0;
    logic [10:0] last_act_row = '0;
    logic        rcd_active = 1'b0;
    int          rcd_run = 0;
    int          last_rcd = 0;
    logic [10:0] last_cas_col = '0;
    logic [3:0]  last_wen = 4'hF;
    int          cas_run = 0;
    int          last_cas_len = 0;
    int          n_acc = 0;
    int          n_resp = 0;
    logic [32:0] rq [$];

    // Bus monitor and DRAM model, evaluated away from the active edge.
    always @(negedge cpu_clk) begin
        if (!cpu_rst_n) begin
            prev_ras   = 1'b1;
            prev_cas   = 1'b1;
            pre_run    = 0;
            rcd_active = 1'b0;
            rd_cnt     = 0;
            DRAM_valid = 1'b0;
        end else begin
            if (!DRAM_CSn && DRAM_RASn) begin
                pre_run++;
            end else if (pre_run != 0) begin
                last_pre_len = pre_run;
                pre_run = 0;
                pre_events++;
            end
            if (!DRAM_RASn && prev_ras) begin
                act_events++;
                last_act_row = DRAM_A;
                cur_row = DRAM_A;
                rcd_run = 0;
                rcd_active = 1'b1;
            end
            if (rcd_active) begin
                if (DRAM_CASn) begin
                    rcd_run++;
                end else begin
                    last_rcd = rcd_run;
                    rcd_active = 1'b0;
                end
            end
            if (!DRAM_CASn && prev_cas) begin
                last_cas_col = DRAM_A;
                cas_run = 0;
                if (DRAM_WEn != 4'hF) last_wen = DRAM_WEn;
            end
            if (!DRAM_CASn) cas_run++;
            else if (!prev_cas) last_cas_len = cas_run;
            if (resp_valid) begin
                rq.push_back({resp_err, resp_rdata});
                n_resp++;
            end
            if (req_valid && req_ready) n_acc++;

            if (!DRAM_CASn && DRAM_WEn != 4'hF) begin
                int k;
                bit [31:0] w;
                k = int'({cur_row, DRAM_A[9:0]});
                w = mem.exists(k) ? mem[k] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (!DRAM_WEn[b]) w[8*b +: 8] = DRAM_D[8*b +: 8];
                mem[k] = w;
            end
            if (!DRAM_CASn && DRAM_WEn == 4'hF) begin
                int k;
                k = int'({cur_row, DRAM_A[9:0]});
                rd_cnt++;
                if (rd_cnt == 3 && !no_valid) begin
                    DRAM_valid = 1'b1;
                    DRAM_Q = mem.exists(k) ? mem[k] : 32'h0;
                end else begin
                    DRAM_valid = 1'b0;
                end
            end else begin
                rd_cnt = 0;
                DRAM_valid = 1'b0;
            end
            prev_ras = DRAM_RASn;
            prev_cas = DRAM_CASn;
        end
    end

    task automatic issue(input logic w, input logic [20:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        @(negedge cpu_clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wstrb = s;
        req_wdata = d;
        while (!req_ready && n < 2000) begin
            @(negedge cpu_clk);
            n++;
        end
        chk("accept_timeout", 32'(n >= 2000), 32'h0);
        @(posedge cpu_clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output logic e,
                             output logic [31:0] d);
        int n = 0;
        while (rq.size() == 0 && n < 2000) begin
            @(negedge cpu_clk);
            n++;
        end
        chk({tag, "_resp_timeout"}, 32'(rq.size() == 0), 32'h0);
        e = 1'bx;
        d = 'x;
        if (rq.size() != 0) {e, d} = rq.pop_front();
    endtask

    task automatic rd(input string tag, input logic [20:0] a,
                      input logic [31:0] exp);
        logic e;
        logic [31:0] d;
        issue(1'b0, a, 4'h0, 32'h0);
        wait_resp(tag, e, d);
        chk({tag, "_err"}, 32'(e), 32'h0);
        chk({tag, "_data"}, d, exp);
    endtask

    task automatic wr(input string tag, input logic [20:0] a,
                      input logic [3:0] s, input logic [31:0] dat);
        logic e;
        logic [31:0] d;
        issue(1'b1, a, s, dat);
        wait_resp(tag, e, d);
        chk({tag, "_err"}, 32'(e), 32'h0);
        chk({tag, "_rdata"}, d, 32'h0);
    endtask

    logic        bb_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [20:0] bb_a [4] = '{21'h00410, 21'h00410, 21'h00C10, 21'h00C10};
    logic [3:0]  bb_s [4] = '{4'hF, 4'h0, 4'b1010, 4'h0};
    logic [31:0] bb_d [4] = '{32'hA1B2C3D4, 32'h0, 32'h0F1E2D3C, 32'h0};
    logic [31:0] bb_x [4] = '{32'h0, 32'hA1B2C3D4, 32'h0, 32'h0F002D00};

    initial begin
        int act0;
        int pre0;
        int acc0;
        int resp0;
        logic e;
        logic [31:0] d;

        cpu_rst_n  = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wstrb  = '0;
        req_wdata  = '0;
        DRAM_Q     = '0;
        DRAM_valid = 1'b0;
        mem[32'h403] = 32'hDEADBEEF;
        mem[32'h803] = 32'h0BADF00D;

        // Reset state
        repeat (2) @(negedge cpu_clk);
        chk("rst_csn", 32'(DRAM_CSn), 32'h1);
        chk("rst_rasn", 32'(DRAM_RASn), 32'h1);
        chk("rst_casn", 32'(DRAM_CASn), 32'h1);
        chk("rst_wen", 32'(DRAM_WEn), 32'hF);
        chk("rst_a", 32'(DRAM_A), 32'h0);
        chk("rst_d", DRAM_D, 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_resp", 32'({resp_valid, resp_err}), 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        #2 cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        chk("rel_ready", 32'(req_ready), 32'h1);

        // Cold read: ACT row 1 for 5 cycles, CAS column 3
        act0 = act_events;
        rd("cold", 21'h00403, 32'hDEADBEEF);
        chk("cold_act", 32'(act_events - act0), 32'h1);
        chk("cold_row", 32'(last_act_row), 32'h1);
        chk("cold_rcd", 32'(last_rcd), 32'h5);
        chk("cold_col", 32'(last_cas_col), 32'h3);

        // Row-hit write then read
        act0 = act_events;
        pre0 = pre_events;
        wr("hit_wr", 21'h00404, 4'b0011, 32'h12345678);
        chk("hit_wen", 32'(last_wen), 32'hC);
        rd("hit_rd", 21'h00404, 32'h00005678);
        chk("hit_no_act", 32'(act_events - act0), 32'h0);
        chk("hit_no_pre", 32'(pre_events - pre0), 32'h0);

        // Empty byte mask still acknowledges and changes nothing
        wr("nop_wr", 21'h00404, 4'h0, 32'hFFFFFFFF);
        rd("nop_rd", 21'h00404, 32'h00005678);

        // Row miss: precharge 5 cycles, then ACT row 2
        act0 = act_events;
        pre0 = pre_events;
        rd("miss", 21'h00803, 32'h0BADF00D);
        chk("miss_pre", 32'(pre_events - pre0), 32'h1);
        chk("miss_pre_len", 32'(last_pre_len), 32'h5);
        chk("miss_act", 32'(act_events - act0), 32'h1);
        chk("miss_row", 32'(last_act_row), 32'h2);

        // Timeout: no DRAM_valid for the whole wait window
        no_valid = 1'b1;
        issue(1'b0, 21'h00805, 4'h0, 32'h0);
        wait_resp("tmo", e, d);
        chk("tmo_err", 32'(e), 32'h1);
        chk("tmo_rdata", d, 32'h0);
        chk("tmo_cas_len", 32'(last_cas_len), 32'd256);
        no_valid = 1'b0;
        repeat (8) @(negedge cpu_clk);
        chk("tmo_pre_len", 32'(last_pre_len), 32'h5);
        chk("tmo_csn_idle", 32'(DRAM_CSn), 32'h1);
        act0 = act_events;
        rd("post_tmo", 21'h00403, 32'hDEADBEEF);
        chk("post_tmo_act", 32'(act_events - act0), 32'h1);
        chk("post_tmo_row", 32'(last_act_row), 32'h1);

        // Reset in the middle of a read wait
        no_valid = 1'b1;
        issue(1'b0, 21'h00403, 4'h0, 32'h0);
        repeat (10) @(negedge cpu_clk);
        chk("mid_in_read", 32'(DRAM_CASn), 32'h0);
        resp0 = n_resp;
        #2 cpu_rst_n = 1'b0;
        #1;
        chk("mid_rst_csn", 32'(DRAM_CSn), 32'h1);
        chk("mid_rst_rasn", 32'(DRAM_RASn), 32'h1);
        chk("mid_rst_casn", 32'(DRAM_CASn), 32'h1);
        chk("mid_rst_wen", 32'(DRAM_WEn), 32'hF);
        repeat (3) @(negedge cpu_clk);
        no_valid = 1'b0;
        #2 cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        chk("mid_rel_ready", 32'(req_ready), 32'h1);
        repeat (5) @(negedge cpu_clk);
        chk("mid_no_resp", 32'(n_resp - resp0), 32'h0);
        act0 = act_events;
        rd("mid_after", 21'h00403, 32'hDEADBEEF);
        chk("mid_after_act", 32'(act_events - act0), 32'h1);

        // Back-to-back with req_valid held high
        acc0 = n_acc;
        act0 = act_events;
        @(negedge cpu_clk);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            req_write = bb_w[i];
            req_addr  = bb_a[i];
            req_wstrb = bb_s[i];
            req_wdata = bb_d[i];
            while (!req_ready && n < 2000) begin
                @(negedge cpu_clk);
                n++;
            end
            chk("bb_accept_timeout", 32'(n >= 2000), 32'h0);
            @(posedge cpu_clk);
            #1;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_resp("bb", e, d);
            chk($sformatf("bb%0d_err", i), 32'(e), 32'h0);
            chk($sformatf("bb%0d_data", i), d, bb_x[i]);
        end
        chk("bb_accepts", 32'(n_acc - acc0), 32'h4);
        chk("bb_act", 32'(act_events - act0), 32'h1);
        chk("bb_row", 32'(last_act_row), 32'h3);
        chk("bb_wen", 32'(last_wen), 32'h5);
        repeat (4) @(negedge cpu_clk);
        chk("bb_no_extra", 32'(rq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
